// File: rtl/updown_gray_counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter with Gray output.
package updown_gray_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Widest counter the Gray helper supports; callers cast down to their own width.
  localparam int GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/dff_reg_sr.sv
// W-bit D register with synchronous active-high clear to zero.
module dff_reg_sr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/updown_gray_counter.sv
// Up/down modulo counter with binary + Gray outputs, load, enable,
// wrap/saturate limits and a registered terminal-count flag.
module updown_gray_counter
  import updown_gray_counter_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int MODULUS  = 2**WIDTH,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] next_count,
  output logic             tc
);

  // Limits are explicit constants so a non-power-of-two modulus never relies on overflow.
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam bit               SAT     = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] count_d, count_q;
  logic             tc_d, tc_q;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load) begin
      count_d = (load_val > MAX_CNT) ? MAX_CNT : load_val;
    end else if (en) begin
      if (dir == DIR_UP) begin
        if (count_q >= MAX_CNT) begin
          tc_d    = 1'b1;
          count_d = SAT ? MAX_CNT : '0;
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (count_q == '0) begin
          tc_d    = 1'b1;
          count_d = SAT ? '0 : MAX_CNT;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  dff_reg_sr #(.W(WIDTH)) u_count_reg (
    .clk   (clk),
    .reset (reset),
    .d     (count_d),
    .q     (count_q)
  );

  dff_reg_sr #(.W(1)) u_tc_reg (
    .clk   (clk),
    .reset (reset),
    .d     (tc_d),
    .q     (tc_q)
  );

  assign count      = count_q;
  assign tc         = tc_q;
  assign next_count = count_d;
  assign gray       = WIDTH'(bin2gray(GRAY_MAX_W'(count_q)));

endmodule

// File: tb/tb_updown_gray_counter.sv
// Bench: three counter configurations (default, MODULUS=6, SATURATE=1) checked by a
// directed vector table and a randomized run against an arithmetic reference model.
module tb_updown_gray_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic       en  [3];
  logic       dir [3];
  logic       ld  [3];
  logic [2:0] lv  [3];
  logic [2:0] cnt [3];
  logic [2:0] gry [3];
  logic [2:0] nxt [3];
  logic       tc  [3];

  int mod_p [3] = '{8, 6, 8};
  bit sat_p [3] = '{1'b0, 1'b0, 1'b1};

  int m_cnt [3];
  int m_tc  [3];
  int total  = 0;
  int passed = 0;

  updown_gray_counter #(.WIDTH(3)) u_def (
    .clk(clk), .reset(rst[0]), .en(en[0]), .dir(dir[0]), .load(ld[0]), .load_val(lv[0]),
    .count(cnt[0]), .gray(gry[0]), .next_count(nxt[0]), .tc(tc[0]));

  updown_gray_counter #(.WIDTH(3), .MODULUS(6)) u_mod6 (
    .clk(clk), .reset(rst[1]), .en(en[1]), .dir(dir[1]), .load(ld[1]), .load_val(lv[1]),
    .count(cnt[1]), .gray(gry[1]), .next_count(nxt[1]), .tc(tc[1]));

  updown_gray_counter #(.WIDTH(3), .SATURATE(1)) u_sat (
    .clk(clk), .reset(rst[2]), .en(en[2]), .dir(dir[2]), .load(ld[2]), .load_val(lv[2]),
    .count(cnt[2]), .gray(gry[2]), .next_count(nxt[2]), .tc(tc[2]));

  typedef struct {
    int       k;
    bit       r, l;
    bit [2:0] v;
    bit       e, d;
    int       ecnt, egray, etc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int k, bit r, bit l, bit [2:0] v, bit e, bit d,
                              int c, int g, int t);
    vec_t x;
    x = '{k, r, l, v, e, d, c, g, t};
    vecs.push_back(x);
  endfunction

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
  endtask

  // Reference: integer state stepped with the modulus rules directly.
  function automatic void model_next(int k, output int nc, output int nt);
    nc = m_cnt[k];
    nt = 0;
    if (rst[k]) begin
      nc = 0;
    end else if (ld[k]) begin
      nc = (int'(lv[k]) > mod_p[k] - 1) ? mod_p[k] - 1 : int'(lv[k]);
    end else if (en[k]) begin
      if (dir[k]) begin
        if (m_cnt[k] + 1 == mod_p[k]) begin
          nt = 1;
          nc = sat_p[k] ? m_cnt[k] : 0;
        end else nc = m_cnt[k] + 1;
      end else begin
        if (m_cnt[k] == 0) begin
          nt = 1;
          nc = sat_p[k] ? 0 : mod_p[k] - 1;
        end else nc = m_cnt[k] - 1;
      end
    end
  endfunction

  task automatic idle();
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0; en[k] = 1'b0; dir[k] = 1'b0; ld[k] = 1'b0; lv[k] = 3'd0;
    end
  endtask

  task automatic cyc();
    int nc [3];
    int nt [3];
    #2;
    for (int k = 0; k < 3; k++) begin
      model_next(k, nc[k], nt[k]);
      if (!rst[k]) chk("next_count", k, 32'(nxt[k]), nc[k]);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = nc[k];
      m_tc[k]  = nt[k];
      chk("count", k, 32'(cnt[k]), m_cnt[k]);
      chk("gray",  k, 32'(gry[k]), m_cnt[k] ^ (m_cnt[k] >> 1));
      chk("tc",    k, 32'(tc[k]),  m_tc[k]);
    end
  endtask

  initial begin
    idle();
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; m_cnt[k] = 0; m_tc[k] = 0;
    end
    @(posedge clk);
    #1;
    cyc();

    // Default: reset, count up through the wrap
    add(0,1,0,0,0,0, 0,0,0);
    add(0,1,0,0,0,0, 0,0,0);
    add(0,0,0,0,1,1, 1,1,0);
    add(0,0,0,0,1,1, 2,3,0);
    add(0,0,0,0,1,1, 3,2,0);
    add(0,0,0,0,1,1, 4,6,0);
    add(0,0,0,0,1,1, 5,7,0);
    add(0,0,0,0,1,1, 6,5,0);
    add(0,0,0,0,1,1, 7,4,0);
    add(0,0,0,0,1,1, 0,0,1);
    add(0,0,0,0,1,1, 1,1,0);
    // Down-count wrap from zero
    add(0,1,0,0,0,0, 0,0,0);
    add(0,0,0,0,1,0, 7,4,1);
    add(0,0,0,0,1,0, 6,5,0);
    // Load beats enable
    add(0,0,1,4,0,0, 4,6,0);
    add(0,0,1,2,1,1, 2,3,0);
    // Reset beats load and enable, then hold
    add(0,0,1,5,0,0, 5,7,0);
    add(0,1,1,3,1,1, 0,0,0);
    add(0,0,0,0,0,0, 0,0,0);
    // MODULUS=6: clamped load, wrap both ways
    add(1,1,0,0,0,0, 0,0,0);
    add(1,0,1,7,0,0, 5,7,0);
    add(1,0,0,0,1,1, 0,0,1);
    add(1,0,0,0,1,0, 5,7,1);
    add(1,0,0,0,1,0, 4,6,0);
    // SATURATE=1: held at limits, tc stays high under continuous enable
    add(2,1,0,0,0,0, 0,0,0);
    add(2,0,1,6,0,0, 6,5,0);
    add(2,0,0,0,1,1, 7,4,0);
    add(2,0,0,0,1,1, 7,4,1);
    add(2,0,0,0,1,1, 7,4,1);
    add(2,0,0,0,1,0, 6,5,0);
    add(2,1,0,0,0,0, 0,0,0);
    add(2,0,0,0,1,0, 0,0,1);
    add(2,0,0,0,1,0, 0,0,1);
    add(2,0,0,0,0,0, 0,0,0);

    foreach (vecs[i]) begin
      idle();
      rst[vecs[i].k] = vecs[i].r;
      ld[vecs[i].k]  = vecs[i].l;
      lv[vecs[i].k]  = vecs[i].v;
      en[vecs[i].k]  = vecs[i].e;
      dir[vecs[i].k] = vecs[i].d;
      cyc();
      chk("vec_count", vecs[i].k, 32'(cnt[vecs[i].k]), vecs[i].ecnt);
      chk("vec_gray",  vecs[i].k, 32'(gry[vecs[i].k]), vecs[i].egray);
      chk("vec_tc",    vecs[i].k, 32'(tc[vecs[i].k]),  vecs[i].etc);
    end

    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 3; k++) begin
        rst[k] = ($urandom % 20) == 0;
        ld[k]  = ($urandom % 8) == 0;
        en[k]  = ($urandom % 4) != 0;
        dir[k] = $urandom % 2;
        lv[k]  = 3'($urandom % 8);
      end
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
